// File: rtl/ad2s1210_sequencer.sv
// ad2s1210_sequencer
// Periodic sampling scheduler and SPI-access arbiter for the AD2S1210 resolver
// path. Produces the read cadence for the resolver reader, interleaves
// on-demand configuration writes, and reports dropped ticks and timeouts.

module ad2s1210_sequencer #(
    parameter int TIMEOUT  = 4096,
    parameter int PERIOD_W = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic [PERIOD_W-1:0] period,
    input  logic [1:0]          read_mode,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [7:0]          cfg_addr,
    input  logic [7:0]          cfg_data,
    output logic                reader_start,
    output logic                reader_type,
    input  logic                reader_done,
    output logic                cfg_start,
    output logic [7:0]          cfg_addr_out,
    output logic [7:0]          cfg_data_out,
    input  logic                cfg_done,
    output logic                busy,
    output logic [15:0]         overrun_count,
    output logic [15:0]         timeout_count,
    output logic                fault
);

    localparam int WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_START,
        RD_WAIT,
        CFG_START,
        CFG_WAIT
    } state_t;

    state_t              state;
    state_t              next_state;
    logic [PERIOD_W-1:0] period_count;
    logic [PERIOD_W-1:0] period_last;
    logic                tick;
    logic                tick_pending;
    logic                drop_tick;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [1:0]          mode_q;
    logic                second_read;
    logic                alt_toggle;
    logic                cfg_pending;
    logic                launch_read;
    logic                chain_second;
    logic                timeout_ev;
    logic                cfg_clear;

    // Periods below 2 are clamped so the cadence never degenerates to every cycle.
    assign period_last = (period < PERIOD_W'(2)) ? PERIOD_W'(1) : period - PERIOD_W'(1);
    assign tick        = enable && (period_count == period_last);
    assign drop_tick   = tick && (tick_pending || state == RD_START || state == RD_WAIT);
    assign cfg_ready   = !cfg_pending;

    // Free-running period counter; a shrunken period makes it wrap on the next cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            period_count <= '0;
        end else if (!enable) begin
            period_count <= '0;
        end else if (period_count >= period_last) begin
            period_count <= '0;
        end else begin
            period_count <= period_count + PERIOD_W'(1);
        end
    end

    // Remember one tick that arrived while a config operation held the converter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tick_pending <= 1'b0;
        end else if (!enable) begin
            tick_pending <= 1'b0;
        end else if (launch_read) begin
            tick_pending <= 1'b0;
        end else if (tick && !drop_tick) begin
            tick_pending <= 1'b1;
        end
    end

    // Next-state decode; reads win over a pending config write.
    always_comb begin
        next_state   = state;
        launch_read  = 1'b0;
        chain_second = 1'b0;
        timeout_ev   = 1'b0;
        cfg_clear    = 1'b0;
        case (state)
            IDLE: begin
                if (tick || tick_pending) begin
                    next_state  = RD_START;
                    launch_read = 1'b1;
                end else if (cfg_pending) begin
                    next_state = CFG_START;
                end
            end
            RD_START: next_state = RD_WAIT;
            RD_WAIT: begin
                if (reader_done) begin
                    if (mode_q == 2'b11 && !second_read) begin
                        next_state   = RD_START;
                        chain_second = 1'b1;
                    end else begin
                        next_state = IDLE;
                    end
                end else if (wait_cnt == WAIT_LAST) begin
                    next_state = IDLE;
                    timeout_ev = 1'b1;
                end
            end
            CFG_START: next_state = CFG_WAIT;
            CFG_WAIT: begin
                if (cfg_done) begin
                    next_state = IDLE;
                    cfg_clear  = 1'b1;
                end else if (wait_cnt == WAIT_LAST) begin
                    next_state = IDLE;
                    cfg_clear  = 1'b1;
                    timeout_ev = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // State register with start pulses and busy registered off the next state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            reader_start <= 1'b0;
            cfg_start    <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= next_state;
            reader_start <= (next_state == RD_START);
            cfg_start    <= (next_state == CFG_START);
            busy         <= (next_state != IDLE);
        end
    end

    // Wait counter runs only while waiting for a done pulse.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else if (state == RD_WAIT || state == CFG_WAIT) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end else begin
            wait_cnt <= '0;
        end
    end

    // Read mode is captured at launch so a mid-sequence change only affects the next tick.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mode_q      <= 2'b00;
            second_read <= 1'b0;
            reader_type <= 1'b0;
            alt_toggle  <= 1'b0;
        end else begin
            if (launch_read) begin
                mode_q      <= read_mode;
                second_read <= 1'b0;
                reader_type <= (read_mode == 2'b01) || (read_mode == 2'b10 && alt_toggle);
            end else if (chain_second) begin
                second_read <= 1'b1;
                reader_type <= 1'b1;
            end
            if (state == RD_WAIT && reader_done && mode_q == 2'b10) begin
                alt_toggle <= !alt_toggle;
            end
        end
    end

    // Single-entry config request buffer; the slot frees on completion or timeout.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cfg_pending  <= 1'b0;
            cfg_addr_out <= 8'h00;
            cfg_data_out <= 8'h00;
        end else if (cfg_clear) begin
            cfg_pending <= 1'b0;
        end else if (cfg_valid && !cfg_pending) begin
            cfg_pending  <= 1'b1;
            cfg_addr_out <= cfg_addr;
            cfg_data_out <= cfg_data;
        end
    end

    // Saturating error counters and a registered one-cycle fault pulse.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            overrun_count <= 16'h0000;
            timeout_count <= 16'h0000;
            fault         <= 1'b0;
        end else begin
            fault <= drop_tick || timeout_ev;
            if (drop_tick && overrun_count != 16'hFFFF) begin
                overrun_count <= overrun_count + 16'd1;
            end
            if (timeout_ev && timeout_count != 16'hFFFF) begin
                timeout_count <= timeout_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_ad2s1210_sequencer.sv
// tb_ad2s1210_sequencer
// Scoreboarded bench: stimulus queues the expected start pulses, a monitor
// pops and compares whenever the sequencer issues a reader or config start.

module tb_ad2s1210_sequencer;

    localparam int TO = 32;

    typedef struct {
        logic       is_cfg;
        logic       rtype;
        logic [7:0] addr;
        logic [7:0] data;
        int         gap;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic [31:0] period;
    logic [1:0]  read_mode;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [7:0]  cfg_addr;
    logic [7:0]  cfg_data;
    logic        reader_start;
    logic        reader_type;
    logic        reader_done = 1'b0;
    logic        cfg_start;
    logic [7:0]  cfg_addr_out;
    logic [7:0]  cfg_data_out;
    logic        cfg_done = 1'b0;
    logic        busy;
    logic [15:0] overrun_count;
    logic [15:0] timeout_count;
    logic        fault;

    exp_t exp_q[$];
    int   checks_total  = 0;
    int   checks_passed = 0;
    int   cyc           = 0;
    int   obs_reads     = 0;
    int   obs_cfgs      = 0;
    int   fault_seen    = 0;
    int   last_start    = 0;
    logic rd_outstanding = 1'b0;
    logic rd_resp_en;
    logic cfg_resp_en;
    logic cfg_force;
    int   rd_delay;
    int   cfg_delay;
    int   rd_timer  = 0;
    int   cfg_timer = 0;

    ad2s1210_sequencer #(.TIMEOUT(TO), .PERIOD_W(32)) dut (
        .clock         (clock),
        .reset         (reset),
        .enable        (enable),
        .period        (period),
        .read_mode     (read_mode),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_addr      (cfg_addr),
        .cfg_data      (cfg_data),
        .reader_start  (reader_start),
        .reader_type   (reader_type),
        .reader_done   (reader_done),
        .cfg_start     (cfg_start),
        .cfg_addr_out  (cfg_addr_out),
        .cfg_data_out  (cfg_data_out),
        .cfg_done      (cfg_done),
        .busy          (busy),
        .overrun_count (overrun_count),
        .timeout_count (timeout_count),
        .fault         (fault)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check_output(input string name, input longint act, input longint exp);
        checks_total++;
        if (act == exp) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input logic is_cfg, input logic rtype, input logic [7:0] addr,
                            input logic [7:0] data, input int gap);
        exp_t e;
        e.is_cfg = is_cfg;
        e.rtype  = rtype;
        e.addr   = addr;
        e.data   = data;
        e.gap    = gap;
        exp_q.push_back(e);
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #2;
    endtask

    task automatic apply_stimulus(input logic en, input logic [31:0] per, input logic [1:0] mode);
        period    = per;
        read_mode = mode;
        enable    = en;
    endtask

    task automatic wait_reads(input int n, input int budget);
        int target = obs_reads + n;
        int k = 0;
        while (obs_reads < target && k < budget) begin
            next_cycle();
            k++;
        end
        check_output("wait_reads", obs_reads, target);
    endtask

    task automatic wait_cfgs(input int n, input int budget);
        int target = obs_cfgs + n;
        int k = 0;
        while (obs_cfgs < target && k < budget) begin
            next_cycle();
            k++;
        end
        check_output("wait_cfgs", obs_cfgs, target);
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (busy && k < budget) begin
            next_cycle();
            k++;
        end
        check_output("wait_idle", busy, 0);
    endtask

    // Reader model: pulses reader_done rd_delay cycles after each start.
    always begin
        @(posedge clock);
        #3;
        if (!reset) begin
            rd_timer    = 0;
            reader_done = 1'b0;
        end else begin
            if (rd_timer > 0) begin
                rd_timer--;
                reader_done = (rd_timer == 0);
            end else begin
                reader_done = 1'b0;
            end
            if (reader_start && rd_resp_en) rd_timer = rd_delay;
        end
    end

    // Config-writer model: pulses cfg_done cfg_delay cycles after each start.
    always begin
        @(posedge clock);
        #3;
        if (!reset) begin
            cfg_timer = 0;
            cfg_done  = cfg_force;
        end else begin
            if (cfg_timer > 0) begin
                cfg_timer--;
                cfg_done = (cfg_timer == 0) || cfg_force;
            end else begin
                cfg_done = cfg_force;
            end
            if (cfg_start && cfg_resp_en) cfg_timer = cfg_delay;
        end
    end

    // Monitor: pop and compare on every start pulse the sequencer issues.
    always begin
        exp_t e;
        @(posedge clock);
        #1;
        if (reset) begin
            if (fault) fault_seen++;
            if (reader_done || !busy) rd_outstanding = 1'b0;
            if (reader_start) begin
                obs_reads++;
                check_output("one_outstanding", rd_outstanding, 0);
                rd_outstanding = 1'b1;
                check_output("sb_has_entry", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check_output("kind_is_read", e.is_cfg, 0);
                    check_output("reader_type", reader_type, e.rtype);
                    if (e.gap >= 0) check_output("read_gap", cyc - last_start, e.gap);
                end
                last_start = cyc;
            end
            if (cfg_start) begin
                obs_cfgs++;
                check_output("sb_has_entry", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check_output("kind_is_cfg", e.is_cfg, 1);
                    check_output("cfg_addr_out", cfg_addr_out, e.addr);
                    check_output("cfg_data_out", cfg_data_out, e.data);
                end
            end
        end
    end

    // Directed scenario sequence.
    initial begin
        int n;
        reset       = 1'b0;
        enable      = 1'b0;
        period      = 32'd100;
        read_mode   = 2'b00;
        cfg_valid   = 1'b0;
        cfg_addr    = 8'h00;
        cfg_data    = 8'h00;
        rd_resp_en  = 1'b1;
        cfg_resp_en = 1'b1;
        cfg_force   = 1'b0;
        rd_delay    = 20;
        cfg_delay   = 5;

        repeat (3) next_cycle();
        check_output("rst_busy", busy, 0);
        check_output("rst_cfg_ready", cfg_ready, 1);
        check_output("rst_reader_start", reader_start, 0);
        check_output("rst_cfg_start", cfg_start, 0);
        check_output("rst_fault", fault, 0);
        check_output("rst_overrun", overrun_count, 0);
        check_output("rst_timeout", timeout_count, 0);
        reset = 1'b1;
        next_cycle();
        check_output("post_rst_busy", busy, 0);

        $display("[TB] period 100, position reads");
        push_exp(0, 0, 0, 0, -1);
        push_exp(0, 0, 0, 0, 100);
        push_exp(0, 0, 0, 0, 100);
        apply_stimulus(1, 32'd100, 2'b00);
        wait_reads(3, 400);
        enable = 1'b0;
        wait_idle(100);
        check_output("mode0_overrun", overrun_count, 0);

        $display("[TB] alternate mode");
        push_exp(0, 0, 0, 0, -1);
        push_exp(0, 1, 0, 0, 40);
        push_exp(0, 0, 0, 0, 40);
        push_exp(0, 1, 0, 0, 40);
        apply_stimulus(1, 32'd40, 2'b10);
        wait_reads(4, 300);
        enable = 1'b0;
        wait_idle(100);

        $display("[TB] position then velocity mode");
        push_exp(0, 0, 0, 0, -1);
        push_exp(0, 1, 0, 0, 21);
        push_exp(0, 0, 0, 0, 39);
        push_exp(0, 1, 0, 0, 21);
        apply_stimulus(1, 32'd60, 2'b11);
        wait_reads(4, 300);
        enable = 1'b0;
        wait_idle(100);

        $display("[TB] overrun with slow reader");
        rd_delay = 25;
        push_exp(0, 0, 0, 0, -1);
        push_exp(0, 0, 0, 0, 30);
        push_exp(0, 0, 0, 0, 30);
        apply_stimulus(1, 32'd10, 2'b00);
        wait_reads(3, 200);
        enable = 1'b0;
        wait_idle(100);
        check_output("overrun_count", overrun_count, 4);
        check_output("overrun_faults", fault_seen, 4);

        $display("[TB] config request colliding with a tick");
        rd_delay = 20;
        push_exp(0, 0, 0, 0, -1);
        push_exp(1, 0, 8'h91, 8'h7F, -1);
        apply_stimulus(1, 32'd20, 2'b00);
        repeat (19) next_cycle();
        cfg_valid = 1'b1;
        cfg_addr  = 8'h91;
        cfg_data  = 8'h7F;
        next_cycle();
        cfg_valid = 1'b0;
        cfg_addr  = 8'h00;
        cfg_data  = 8'h00;
        enable    = 1'b0;
        check_output("cfg_ready_low", cfg_ready, 0);
        check_output("read_first_busy", busy, 1);
        wait_cfgs(1, 100);
        wait_idle(100);
        check_output("cfg_ready_back", cfg_ready, 1);

        $display("[TB] read timeout then recovery");
        rd_resp_en = 1'b0;
        push_exp(0, 0, 0, 0, -1);
        push_exp(0, 0, 0, 0, 60);
        apply_stimulus(1, 32'd60, 2'b00);
        wait_reads(1, 100);
        n = 0;
        do begin
            next_cycle();
            n++;
        end while (busy && n < 100);
        check_output("timeout_latency", n - 1, TO);
        check_output("timeout_count", timeout_count, 1);
        rd_resp_en = 1'b1;
        wait_reads(1, 100);
        enable = 1'b0;
        wait_idle(100);
        check_output("total_faults", fault_seen, 5);
        check_output("overrun_kept", overrun_count, 4);

        $display("[TB] reset during config wait");
        cfg_resp_en = 1'b0;
        push_exp(1, 0, 8'h3C, 8'hA5, -1);
        cfg_valid = 1'b1;
        cfg_addr  = 8'h3C;
        cfg_data  = 8'hA5;
        next_cycle();
        cfg_valid = 1'b0;
        wait_cfgs(1, 20);
        repeat (3) next_cycle();
        check_output("in_cfg_wait_busy", busy, 1);
        #1 reset = 1'b0;
        #1;
        check_output("async_busy", busy, 0);
        check_output("async_cfg_ready", cfg_ready, 1);
        check_output("async_addr_out", cfg_addr_out, 0);
        check_output("async_data_out", cfg_data_out, 0);
        check_output("async_overrun", overrun_count, 0);
        check_output("async_timeout", timeout_count, 0);
        check_output("async_fault", fault, 0);
        next_cycle();
        reset = 1'b1;
        next_cycle();
        cfg_force = 1'b1;
        next_cycle();
        cfg_force = 1'b0;
        repeat (3) next_cycle();
        check_output("late_done_busy", busy, 0);
        check_output("late_done_ready", cfg_ready, 1);
        check_output("late_done_cfgs", obs_cfgs, 2);

        check_output("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
